// File: rtl/f2c_dma_writer.sv
// FPGA-to-host DMA write engine: fills a 16-QW burst buffer, then emits one data MWr
// into the host ring followed by a 1-DW MWr that publishes the new producer pointer.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_FILL  | accept application QWs until the burst buffer is full
// S_DHDR0 | data TLP header beat {DW1, DW0} (SOP)
// S_DHDR1 | data TLP address beat
// S_DPAY  | data TLP payload beats buffer[0..15], EOP on the last
// S_PHDR0 | pointer TLP header beat (SOP)
// S_PHDR1 | pointer TLP address beat (base + 0x800)
// S_PDATA | pointer TLP data beat carrying the updated write pointer (EOP)
module f2c_dma_writer #(
    parameter int SLOT_LOG2 = 4,
    parameter int BURST_QW  = 16
) (
    input  logic                 clk_in,
    input  logic                 rstn,
    input  logic [12:0]          cfgBusDev_in,
    input  logic                 dmaEnable_in,
    input  logic [31:0]          f2cBase_in,
    input  logic [SLOT_LOG2-1:0] f2cRdPtr_in,
    input  logic [63:0]          f2cData_in,
    input  logic                 f2cValid_in,
    output logic                 f2cReady_out,
    output logic [63:0]          txData_out,
    output logic                 txValid_out,
    input  logic                 txReady_in,
    output logic                 txSOP_out,
    output logic                 txEOP_out,
    output logic [SLOT_LOG2-1:0] wrPtr_out
);

    localparam int FILL_W     = $clog2(BURST_QW + 1);
    localparam int IDX_W      = $clog2(BURST_QW);
    localparam int SLOT_SHIFT = $clog2(BURST_QW * 8);
    localparam logic [31:0] DATA_DW0 = 32'h4000_0000 | 32'(BURST_QW * 2);
    localparam logic [31:0] PTR_DW0  = 32'h4000_0001;

    typedef enum logic [2:0] {
        S_FILL,
        S_DHDR0,
        S_DHDR1,
        S_DPAY,
        S_PHDR0,
        S_PHDR1,
        S_PDATA
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [FILL_W-1:0]     r_fill;
    logic [SLOT_LOG2-1:0]  r_wr_ptr;
    logic [IDX_W-1:0]      r_pay_idx;
    logic [63:0]           r_buf [BURST_QW];

    logic [15:0]           w_req_id;
    logic [31:0]           w_base_addr;
    logic [31:0]           w_data_addr;
    logic [31:0]           w_ptr_addr;
    logic [SLOT_LOG2-1:0]  w_wr_ptr_inc;
    logic                  w_ring_full;
    logic                  w_fill_done;
    logic                  w_pay_last;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_tx_valid;
    logic                  w_tx_sop;
    logic                  w_tx_eop;
    logic [63:0]           w_tx_data;
    logic                  w_unused_base;

    assign w_req_id      = {cfgBusDev_in, 3'b000};
    assign w_base_addr   = {f2cBase_in[28:0], 3'b000};
    assign w_data_addr   = w_base_addr + (32'(r_wr_ptr) << SLOT_SHIFT);
    assign w_ptr_addr    = w_base_addr + 32'h0000_0800;
    assign w_unused_base = ^f2cBase_in[31:29];

    // One slot is always left empty so that wrPtr == rdPtr means "ring empty".
    assign w_wr_ptr_inc  = r_wr_ptr + 1'b1;
    assign w_ring_full   = (w_wr_ptr_inc == f2cRdPtr_in);
    assign w_fill_done   = (r_fill == FILL_W'(BURST_QW));
    assign w_pay_last    = (r_pay_idx == IDX_W'(BURST_QW - 1));

    assign w_ready       = dmaEnable_in && (r_state == S_FILL) && (r_fill < FILL_W'(BURST_QW));
    assign w_accept      = w_ready && f2cValid_in;

    always_comb begin
        w_next     = r_state;
        w_tx_valid = 1'b0;
        w_tx_sop   = 1'b0;
        w_tx_eop   = 1'b0;
        w_tx_data  = 64'h0;
        case (r_state)
            S_FILL: begin
                if (w_fill_done && !w_ring_full && dmaEnable_in) begin
                    w_next = S_DHDR0;
                end
            end
            S_DHDR0: begin
                w_tx_valid = 1'b1;
                w_tx_sop   = 1'b1;
                w_tx_data  = {w_req_id, 8'h00, 8'hFF, DATA_DW0};
                if (txReady_in) w_next = S_DHDR1;
            end
            S_DHDR1: begin
                w_tx_valid = 1'b1;
                w_tx_data  = {32'h0, w_data_addr};
                if (txReady_in) w_next = S_DPAY;
            end
            S_DPAY: begin
                w_tx_valid = 1'b1;
                w_tx_eop   = w_pay_last;
                w_tx_data  = r_buf[r_pay_idx];
                if (txReady_in && w_pay_last) w_next = S_PHDR0;
            end
            S_PHDR0: begin
                w_tx_valid = 1'b1;
                w_tx_sop   = 1'b1;
                w_tx_data  = {w_req_id, 8'h00, 8'h0F, PTR_DW0};
                if (txReady_in) w_next = S_PHDR1;
            end
            S_PHDR1: begin
                w_tx_valid = 1'b1;
                w_tx_data  = {32'h0, w_ptr_addr};
                if (txReady_in) w_next = S_PDATA;
            end
            S_PDATA: begin
                w_tx_valid = 1'b1;
                w_tx_eop   = 1'b1;
                w_tx_data  = {32'h0, {(32 - SLOT_LOG2){1'b0}}, r_wr_ptr};
                if (txReady_in) w_next = S_FILL;
            end
            default: w_next = S_FILL;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rstn) begin
            r_state   <= S_FILL;
            r_fill    <= '0;
            r_wr_ptr  <= '0;
            r_pay_idx <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_FILL: begin
                    if (!dmaEnable_in) begin
                        r_fill   <= '0;
                        r_wr_ptr <= '0;
                    end else if (w_accept) begin
                        r_fill <= r_fill + 1'b1;
                    end
                end
                S_DPAY: begin
                    if (txReady_in) begin
                        if (w_pay_last) begin
                            r_pay_idx <= '0;
                            r_wr_ptr  <= w_wr_ptr_inc;
                            r_fill    <= '0;
                        end else begin
                            r_pay_idx <= r_pay_idx + 1'b1;
                        end
                    end
                end
                S_PDATA: begin
                    // A disabled engine restarts the ring from slot 0.
                    if (txReady_in && !dmaEnable_in) begin
                        r_wr_ptr <= '0;
                        r_fill   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_accept) begin
            r_buf[r_fill[IDX_W-1:0]] <= f2cData_in;
        end
    end

    assign f2cReady_out = w_ready;
    assign txValid_out  = w_tx_valid;
    assign txSOP_out    = w_tx_sop;
    assign txEOP_out    = w_tx_eop;
    assign txData_out   = w_tx_data;
    assign wrPtr_out    = r_wr_ptr;

endmodule

// File: tb/tb_f2c_dma_writer.sv
// Directed bench for f2c_dma_writer: feeds bursts, captures every accepted tx beat
// and compares it against hand-built data and pointer TLPs.
module tb_f2c_dma_writer;

    logic        clk_in;
    logic        rstn;
    logic [12:0] cfgBusDev_in;
    logic        dmaEnable_in;
    logic [31:0] f2cBase_in;
    logic [3:0]  f2cRdPtr_in;
    logic [63:0] f2cData_in;
    logic        f2cValid_in;
    logic        f2cReady_out;
    logic [63:0] txData_out;
    logic        txValid_out;
    logic        txReady_in;
    logic        txSOP_out;
    logic        txEOP_out;
    logic [3:0]  wrPtr_out;

    int checks = 0;
    int errors = 0;
    bit rnd_mode = 0;
    logic [65:0] tx_q[$];

    f2c_dma_writer #(.SLOT_LOG2(4), .BURST_QW(16)) u_dut (
        .clk_in       (clk_in),
        .rstn         (rstn),
        .cfgBusDev_in (cfgBusDev_in),
        .dmaEnable_in (dmaEnable_in),
        .f2cBase_in   (f2cBase_in),
        .f2cRdPtr_in  (f2cRdPtr_in),
        .f2cData_in   (f2cData_in),
        .f2cValid_in  (f2cValid_in),
        .f2cReady_out (f2cReady_out),
        .txData_out   (txData_out),
        .txValid_out  (txValid_out),
        .txReady_in   (txReady_in),
        .txSOP_out    (txSOP_out),
        .txEOP_out    (txEOP_out),
        .wrPtr_out    (wrPtr_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        txReady_in = 1'b1;
        forever begin
            @(posedge clk_in);
            #1;
            txReady_in = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Beats transfer at the following posedge; inputs are stable at the negedge.
    always @(negedge clk_in) begin
        if (rstn && txValid_out && txReady_in)
            tx_q.push_back({txSOP_out, txEOP_out, txData_out});
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] seq64(input int n);
        logic [31:0] u;
        u = 32'(n);
        return {32'hC0DE_0000 + u, 32'h1357_9BDF ^ u};
    endfunction

    task automatic feed_burst(input int b);
        for (int i = 0; i < 16; i++) begin
            int n;
            n = 0;
            f2cData_in  = seq64(b * 16 + i);
            f2cValid_in = 1'b1;
            @(negedge clk_in);
            while (!f2cReady_out && n < 2000) begin
                @(negedge clk_in);
                n++;
            end
            if (!f2cReady_out) check("feed_timeout", {65'b0, f2cReady_out}, 66'd1);
            @(posedge clk_in);
            #1;
        end
        f2cValid_in = 1'b0;
    endtask

    task automatic expect_beat(input string tag, input logic [65:0] exp);
        int n;
        n = 0;
        while (tx_q.size() == 0 && n < 5000) begin
            @(posedge clk_in);
            n++;
        end
        if (tx_q.size() == 0) begin
            check({tag, "_timeout"}, 66'(tx_q.size()), 66'd1);
            return;
        end
        check(tag, tx_q.pop_front(), exp);
    endtask

    task automatic check_tlps(input int b, input int slot, input logic [31:0] base,
                              input logic [15:0] reqid, input logic [3:0] ptr);
        logic [31:0] byte_base;
        byte_base = {base[28:0], 3'b000};
        expect_beat("d_hdr0", {2'b10, reqid, 8'h00, 8'hFF, 32'h4000_0020});
        expect_beat("d_addr", {2'b00, 32'h0, byte_base + 32'(slot) * 32'd128});
        for (int i = 0; i < 16; i++)
            expect_beat("d_pay", {1'b0, (i == 15), seq64(b * 16 + i)});
        expect_beat("p_hdr0", {2'b10, reqid, 8'h00, 8'h0F, 32'h4000_0001});
        expect_beat("p_addr", {2'b00, 32'h0, byte_base + 32'h800});
        expect_beat("p_data", {2'b01, 32'h0, 28'h0, ptr});
    endtask

    task automatic wait_beats(input int cnt);
        int n;
        n = 0;
        while (tx_q.size() < cnt && n < 5000) begin
            @(posedge clk_in);
            n++;
        end
        if (tx_q.size() < cnt) check("wait_beats_timeout", 66'(tx_q.size()), 66'(cnt));
    endtask

    initial begin
        rstn         = 1'b0;
        cfgBusDev_in = 13'h0;
        dmaEnable_in = 1'b0;
        f2cBase_in   = 32'h0;
        f2cRdPtr_in  = 4'h0;
        f2cData_in   = 64'h0;
        f2cValid_in  = 1'b0;
        repeat (4) @(posedge clk_in);
        #1;
        check("rst_outputs", {txValid_out, txSOP_out, txEOP_out, f2cReady_out, wrPtr_out, 58'h0},
              66'h0);
        check("rst_data", {2'b0, txData_out}, 66'h0);
        rstn = 1'b1;
        dmaEnable_in = 1'b1;
        @(posedge clk_in);
        #1;
        check("ready_after_en", {65'b0, f2cReady_out}, 66'd1);

        // First burst: latency from 16th accept to SOP is one cycle.
        feed_burst(0);
        check("lat_not_yet", {64'b0, txValid_out, txSOP_out}, 66'b00);
        @(posedge clk_in);
        #1;
        check("lat_sop", {64'b0, txValid_out, txSOP_out}, 66'b11);
        check_tlps(0, 0, 32'h0, 16'h0000, 4'd1);
        #1;
        check("wrptr_after_first", {62'b0, wrPtr_out}, 66'd1);

        // Fill the ring with rdPtr held at 0: 15 usable slots.
        for (int b = 1; b < 15; b++) begin
            feed_burst(b);
            check_tlps(b, b, 32'h0, 16'h0000, 4'(b + 1));
        end
        feed_burst(15);
        repeat (30) @(posedge clk_in);
        #1;
        check("stall_no_tx", 66'(tx_q.size()), 66'd0);
        check("stall_flags", {63'b0, txValid_out, txSOP_out, f2cReady_out}, 66'd0);
        check("stall_wrptr", {62'b0, wrPtr_out}, 66'd15);
        f2cRdPtr_in = 4'd1;
        check_tlps(15, 15, 32'h0, 16'h0000, 4'd0);
        f2cRdPtr_in = 4'd0;

        // Random transmitter backpressure.
        rnd_mode = 1;
        feed_burst(16);
        check_tlps(16, 0, 32'h0, 16'h0000, 4'd1);
        rnd_mode = 0;
        repeat (3) @(posedge clk_in);
        #1;

        // Brief disable in S_FILL resets the pointer.
        dmaEnable_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        check("dis_wrptr", {62'b0, wrPtr_out}, 66'd0);
        check("dis_ready", {65'b0, f2cReady_out}, 66'd0);
        dmaEnable_in = 1'b1;

        // Nonzero base and requester ID.
        f2cBase_in   = 32'h20;
        cfgBusDev_in = 13'h0008;
        feed_burst(17);
        check_tlps(17, 0, 32'h20, 16'h0040, 4'd1);

        // Drop enable mid-payload: both TLPs complete, then pointer resets.
        feed_burst(18);
        wait_beats(8);
        #1;
        dmaEnable_in = 1'b0;
        check_tlps(18, 1, 32'h20, 16'h0040, 4'd2);
        #1;
        check("drop_wrptr", {62'b0, wrPtr_out}, 66'd0);
        check("drop_ready", {65'b0, f2cReady_out}, 66'd0);
        repeat (3) @(posedge clk_in);
        #1;
        check("drop_idle", {64'b0, txValid_out, f2cReady_out}, 66'd0);
        dmaEnable_in = 1'b1;
        feed_burst(19);
        check_tlps(19, 0, 32'h20, 16'h0040, 4'd1);

        // Reset in the middle of a data TLP.
        feed_burst(20);
        wait_beats(5);
        #1;
        rstn = 1'b0;
        dmaEnable_in = 1'b0;
        @(posedge clk_in);
        #1;
        check("midrst_outputs", {txValid_out, txSOP_out, txEOP_out, f2cReady_out, wrPtr_out, 58'h0},
              66'h0);
        check("midrst_data", {2'b0, txData_out}, 66'h0);
        tx_q.delete();
        rstn = 1'b1;
        dmaEnable_in = 1'b1;
        @(posedge clk_in);
        #1;
        feed_burst(21);
        check_tlps(21, 0, 32'h20, 16'h0040, 4'd1);

        repeat (5) @(posedge clk_in);
        #1;
        check("end_no_extra", 66'(tx_q.size()), 66'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/f2c_dma_writer.md
Name: f2c_dma_writer

Overview:
- FPGA-to-host DMA write engine in the pcie-dma app. It sits between the application data source and the TLP transmitter.
- Collects 16 QWs (128 bytes) of application data into a burst buffer. Emits it as one 32-DW posted MWr into a 16-slot host ring at F2C_BASE.
- After each burst, writes the updated write pointer to host address base+0x800 with a 1-DW MWr.
- Host flow control arrives as F2C_RDPTR from the register block, which prevents ring overrun.

Parameters:
- SLOT_LOG2, 4, log2 of ring slot count (16 slots).
- BURST_QW, 16, QWs per data TLP (128 bytes, 32 DW).

Ports:
- clk_in  in  1  PCIe core clock.
- rstn  in  1  Reset, synchronous and active-low.
- cfgBusDev_in  in  13  Bus/device number; requester ID = {cfgBusDev_in, 3'b000}.
- dmaEnable_in  in  1  DMA_ENABLE register bit.
- f2cBase_in  in  32  F2C_BASE register, in QW units; byte address = {f2cBase_in[28:0], 3'b000}.
- f2cRdPtr_in  in  4  F2C_RDPTR register (host consumer pointer).
- f2cData_in  in  64  Application data.
- f2cValid_in  in  1  Data valid.
- f2cReady_out  out  1  Data accepted when valid&ready.
- txData_out  out  64  TLP beat to transmitter.
- txValid_out  out  1  Beat valid.
- txReady_in  in  1  Transmitter ready.
- txSOP_out  out  1  First beat of TLP.
- txEOP_out  out  1  Last beat of TLP.
- wrPtr_out  out  4  Current producer pointer (status/debug).

Behaviour:
- Reset (rstn=0 at a clk_in edge): state=S_FILL, fillCount=0, wrPtr=0, all outputs 0.
- Buffer: 16x64 storage plus 5-bit fillCount.
- f2cReady_out = dmaEnable_in & (state==S_FILL) & (fillCount<16), combinational from registers.
- On accept, write buffer[fillCount] and increment fillCount.
- Ring full when ((wrPtr+1)&0xF)==f2cRdPtr_in, so 15 usable slots.
- S_FILL -> S_DHDR0 when fillCount==16, ring not full, and dmaEnable_in=1. Otherwise hold.
- Tx beats advance only when txValid_out & txReady_in. txValid_out stays high for the whole TLP; no bubbles.
- Data TLP (18 beats):
  - beat0 (SOP) = {DW1, DW0}. DW0 = 32'h4000_0020 (fmt=10, type MWr, length 32). DW1 = {reqID, 8'h00 tag, 8'hFF BEs}.
  - beat1 = {32'h0, addr}, where addr = base + wrPtr*128.
  - beats 2..17 = buffer[0..15]; beat17 has EOP.
  - States: S_DHDR0, S_DHDR1, S_DPAY; a payload index counts 0..15.
- After the EOP of the data TLP: wrPtr <= wrPtr+1 (mod 16) and fillCount <= 0, both in the same cycle. Then go to S_PHDR0.
- Pointer TLP (3 beats):
  - beat0 (SOP) = {DW1, DW0}. DW0 = 32'h4000_0001. DW1 = {reqID, 8'h00, 8'h0F}.
  - beat1 = {32'h0, base+0x800}.
  - beat2 (EOP) = {32'h0, 28'h0, wrPtr}, using the updated wrPtr.
  - Return to S_FILL.
- Address arithmetic is 32-bit modulo. base+0x800 is QW-aligned, so the data sits in the low DW.
- dmaEnable_in falling:
  - A TLP in flight completes. If it is a data TLP, its pointer TLP also completes.
  - On returning to S_FILL with enable=0: wrPtr <= 0 and fillCount <= 0.
  - In S_FILL with enable=0: wrPtr=0, fillCount=0, no accepts.
- Simultaneous events: an f2cRdPtr_in change in the same cycle the full check is made uses the registered input value from that cycle. No accept occurs while transmitting.
- Latency: from the 16th accept to txSOP_out is 1 cycle when the ring has space and txReady_in=1. Burst to pointer EOP is 21 beats.

Test Plan:
- Base=0, rdPtr=0, enable=1, feed SEQ64[0..15] with txReady=1 -> MWr addr 0x0, payload = SEQ64[0..15]. Then pointer MWr to 0x800 with data 1; wrPtr_out=1.
- Hold rdPtr=0 and feed 16 bursts -> exactly 15 data TLPs (pointer values 1..15). The 16th burst is stalled (f2cReady low, no SOP). Set rdPtr=1 -> the 16th TLP goes to slot 15 (addr 0x780), pointer wraps to 0.
- Toggle txReady_in randomly during a burst -> beat sequence unchanged, SOP/EOP exactly once per TLP, no duplicated or dropped QW.
- Base=0x20 -> data addr 0x100, pointer addr 0x900. cfgBusDev=0x0008 -> DW1[31:16]=0x0040.
- Drop enable mid-payload (beat 8) -> data TLP and pointer TLP complete. Then wrPtr_out=0, f2cReady_out=0. Re-enable -> next data TLP at slot 0.
- Assert rstn=0 mid-TLP -> next cycle all outputs 0, state S_FILL. After release, the first burst targets slot 0.
